// File: rtl/ldpc_enc_ctrl_pkg.sv
// rtl/ldpc_enc_ctrl_pkg.sv - shared block geometry defaults for the LDPC encoder control
package ldpc_enc_ctrl_pkg;

  // Default block geometry: data words per block and total words per block
  localparam int cDEF_DATA_SIZE  = 16;
  localparam int cDEF_BLOCK_SIZE = 32;

endpackage

// File: rtl/ldpc_ctrl_step_cnt.sv
// rtl/ldpc_ctrl_step_cnt.sv - step counter with zero/done flags, shared by encoder and decoder FSMs
module ldpc_ctrl_step_cnt
  import ldpc_enc_ctrl_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  // Next count: load restarts at zero; done is raised one step early so it marks the last step
  always_comb begin
    cnt_d  = cnt_q;
    zero_d = zero_q;
    done_d = done_q;
    if (load_i) begin
      cnt_d  = '0;
      zero_d = 1'b1;
      done_d = 1'b0;
    end else if (inc_i) begin
      cnt_d  = cnt_q + CNT_W'(1);
      zero_d = 1'b0;
      done_d = (cnt_q == term_i);
    end
  end

  // Counter registers, frozen while the clock enable is low
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
      done_q <= 1'b0;
    end else if (ena_i) begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = zero_q;
  assign done_o = done_q;

endmodule

// File: rtl/ldpc_enc_ctrl.sv
// rtl/ldpc_enc_ctrl.sv - LDPC encoder main FSM: data phase, parity drain, buffer handshakes
module ldpc_enc_ctrl
  import ldpc_enc_ctrl_pkg::*;
#(
  parameter  int pDATA_SIZE  = cDEF_DATA_SIZE,
  parameter  int pBLOCK_SIZE = cDEF_BLOCK_SIZE,
  localparam int cADDR_W     = $clog2(pBLOCK_SIZE)
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               ibuf_full,
  output logic               obuf_rempty,
  input  logic               iobuf_empty,
  output logic               oobuf_full,
  output logic               ordena,
  output logic [cADDR_W-1:0] oraddr,
  output logic               oparity_mode,
  output logic               openg_clear,
  output logic               openg_sop,
  output logic               openg_val,
  output logic               openg_eop,
  input  logic               ipeng_busy,
  output logic               owrite,
  output logic [cADDR_W-1:0] owaddr
);

  typedef enum logic [2:0] {
    cRESET      = 3'd0,
    cWAIT       = 3'd1,
    cDSTEP      = 3'd2,
    cWAIT_PDONE = 3'd3,
    cPSTEP      = 3'd4,
    cDONE       = 3'd5
  } state_t;

  localparam logic [cADDR_W-1:0] cDATA_TERM   = cADDR_W'(pDATA_SIZE - 2);
  localparam logic [cADDR_W-1:0] cPARITY_TERM = cADDR_W'(pBLOCK_SIZE - pDATA_SIZE - 2);
  localparam logic [cADDR_W-1:0] cPARITY_BASE = cADDR_W'(pDATA_SIZE);

  state_t             state_q, state_d;
  logic [cADDR_W-1:0] cnt;
  logic               cnt_zero, cnt_done;
  logic               step_load, step_inc;
  logic [cADDR_W-1:0] step_term;

  logic               rempty_q, rempty_d;
  logic               full_q, full_d;
  logic               pmode_q, pmode_d;
  logic               clear_q, clear_d;
  logic               sop_q, sop_d;
  logic               val_q, val_d;
  logic               eop_q, eop_d;
  logic               write_q, write_d;
  logic [cADDR_W-1:0] waddr_q, waddr_d;

  // Next-state decode; unknown encodings fall back to cRESET
  always_comb begin
    state_d = state_q;
    case (state_q)
      cRESET:      state_d = cWAIT;
      cWAIT:       if (ibuf_full && iobuf_empty) state_d = cDSTEP;
      cDSTEP:      if (cnt_done) state_d = cWAIT_PDONE;
      cWAIT_PDONE: if (!ipeng_busy) state_d = cPSTEP;
      cPSTEP:      if (cnt_done) state_d = cDONE;
      cDONE:       state_d = cWAIT;
      default:     state_d = cRESET;
    endcase
  end

  // State register
  always_ff @(posedge iclk) begin
    if (ireset) state_q <= cRESET;
    else if (iclkena) state_q <= state_d;
  end

  assign step_load = (state_q == cWAIT) || (state_q == cWAIT_PDONE);
  assign step_inc  = (state_q == cDSTEP) || (state_q == cPSTEP);
  assign step_term = (state_q == cPSTEP) ? cPARITY_TERM : cDATA_TERM;

  ldpc_ctrl_step_cnt #(.CNT_W(cADDR_W)) u_step (
    .clk_i  (iclk),
    .rst_i  (ireset),
    .ena_i  (iclkena),
    .load_i (step_load),
    .inc_i  (step_inc),
    .term_i (step_term),
    .cnt_o  (cnt),
    .zero_o (cnt_zero),
    .done_o (cnt_done)
  );

  assign ordena = step_inc;
  assign oraddr = cnt;

  // Registered output decode; write side trails the read side by the buffer read latency
  always_comb begin
    rempty_d = (state_d == cWAIT_PDONE) && (state_q != cWAIT_PDONE);
    full_d   = (state_d == cDONE);
    clear_d  = (state_d == cWAIT);
    pmode_d  = (state_d == cWAIT_PDONE) || (state_d == cPSTEP) || (state_q == cPSTEP);
    sop_d    = (state_q == cDSTEP) && cnt_zero;
    val_d    = (state_q == cDSTEP);
    eop_d    = (state_q == cDSTEP) && cnt_done;
    write_d  = step_inc;
    waddr_d  = (state_q == cPSTEP) ? (cPARITY_BASE + cnt) : cnt;
  end

  // Output registers
  always_ff @(posedge iclk) begin
    if (ireset) begin
      rempty_q <= 1'b0;
      full_q   <= 1'b0;
      clear_q  <= 1'b0;
      pmode_q  <= 1'b0;
      sop_q    <= 1'b0;
      val_q    <= 1'b0;
      eop_q    <= 1'b0;
      write_q  <= 1'b0;
      waddr_q  <= '0;
    end else if (iclkena) begin
      rempty_q <= rempty_d;
      full_q   <= full_d;
      clear_q  <= clear_d;
      pmode_q  <= pmode_d;
      sop_q    <= sop_d;
      val_q    <= val_d;
      eop_q    <= eop_d;
      write_q  <= write_d;
      waddr_q  <= waddr_d;
    end
  end

  assign obuf_rempty  = rempty_q;
  assign oobuf_full   = full_q;
  assign openg_clear  = clear_q;
  assign oparity_mode = pmode_q;
  assign openg_sop    = sop_q;
  assign openg_val    = val_q;
  assign openg_eop    = eop_q;
  assign owrite       = write_q;
  assign owaddr       = waddr_q;

endmodule

// File: tb/tb_ldpc_enc_ctrl.sv
// tb/tb_ldpc_enc_ctrl.sv - scoreboard bench for ldpc_enc_ctrl with 4 data / 8 total words
module tb_ldpc_enc_ctrl;

  logic       iclk = 1'b0;
  logic       ireset, iclkena, ibuf_full, iobuf_empty, ipeng_busy;
  logic       obuf_rempty, oobuf_full, ordena, oparity_mode;
  logic       openg_clear, openg_sop, openg_val, openg_eop, owrite;
  logic [2:0] oraddr, owaddr;

  always #5 iclk = ~iclk;

  ldpc_enc_ctrl #(.pDATA_SIZE(4), .pBLOCK_SIZE(8)) dut (
    .iclk         (iclk),
    .ireset       (ireset),
    .iclkena      (iclkena),
    .ibuf_full    (ibuf_full),
    .obuf_rempty  (obuf_rempty),
    .iobuf_empty  (iobuf_empty),
    .oobuf_full   (oobuf_full),
    .ordena       (ordena),
    .oraddr       (oraddr),
    .oparity_mode (oparity_mode),
    .openg_clear  (openg_clear),
    .openg_sop    (openg_sop),
    .openg_val    (openg_val),
    .openg_eop    (openg_eop),
    .ipeng_busy   (ipeng_busy),
    .owrite       (owrite),
    .owaddr       (owaddr)
  );

  typedef struct {
    int         cyc;
    logic       rd;
    logic [2:0] raddr;
    logic       wr;
    logic [2:0] waddr;
    logic       pm;
    logic       rem;
    logic       full;
    logic       sop;
    logic       val;
    logic       eop;
  } ev_t;

  ev_t  sb[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   ecyc = 0;
  logic last_en = 1'b0;
  logic armed = 1'b0;
  logic gate = 1'b0;
  int   c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle outputs of one block whose start is sampled in enabled cycle c0
  task automatic push_block(input int start, input int busy, input int maxoff);
    for (int off = 1; off <= 10 + busy; off++) begin
      ev_t e;
      if (off <= maxoff) begin
        e.cyc   = start + off;
        e.rd    = (off <= 4) || (off >= 6 + busy && off <= 9 + busy);
        e.raddr = (off <= 4) ? 3'(off - 1) : 3'(off - 6 - busy);
        e.wr    = (off >= 2 && off <= 5) || (off >= 7 + busy && off <= 10 + busy);
        e.waddr = (off <= 5) ? 3'(off - 2) : 3'(off - 3 - busy);
        e.pm    = (off >= 5) && (off <= 10 + busy);
        e.rem   = (off == 5);
        e.full  = (off == 10 + busy);
        e.sop   = (off == 2);
        e.val   = (off >= 2) && (off <= 5);
        e.eop   = (off == 5);
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_ecyc(input int target);
    int guard = 0;
    while (ecyc < target && guard < 2000) begin
      @(negedge iclk);
      if (gate) iclkena = ~iclkena;
      guard++;
    end
    chk("wait_timeout", 32'(ecyc >= target), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ordena"}, ordena, 0);
    chk({tag, "_oraddr"}, oraddr, 0);
    chk({tag, "_owrite"}, owrite, 0);
    chk({tag, "_owaddr"}, owaddr, 0);
    chk({tag, "_rempty"}, obuf_rempty, 0);
    chk({tag, "_full"}, oobuf_full, 0);
    chk({tag, "_pmode"}, oparity_mode, 0);
    chk({tag, "_clear"}, openg_clear, 0);
    chk({tag, "_sop"}, openg_sop, 0);
    chk({tag, "_val"}, openg_val, 0);
    chk({tag, "_eop"}, openg_eop, 0);
  endtask

  always @(posedge iclk) begin
    last_en <= iclkena && !ireset;
    if (iclkena && !ireset) ecyc <= ecyc + 1;
  end

  // Scoreboard monitor: every enabled cycle is compared, idle when nothing is queued for it
  always @(negedge iclk) begin
    if (armed && last_en) begin
      ev_t e;
      e = '{default: 0};
      e.cyc = ecyc;
      if (sb.size() > 0 && sb[0].cyc < ecyc) begin
        chk("sb_stale", 32'(sb[0].cyc), 32'(ecyc));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == ecyc) e = sb.pop_front();
      chk("ordena", ordena, e.rd);
      if (e.rd) chk("oraddr", oraddr, e.raddr);
      chk("owrite", owrite, e.wr);
      if (e.wr) chk("owaddr", owaddr, e.waddr);
      chk("oparity_mode", oparity_mode, e.pm);
      chk("obuf_rempty", obuf_rempty, e.rem);
      chk("oobuf_full", oobuf_full, e.full);
      chk("openg_sop", openg_sop, e.sop);
      chk("openg_val", openg_val, e.val);
      chk("openg_eop", openg_eop, e.eop);
    end
  end

  initial begin
    ireset = 1'b1; iclkena = 1'b1; ibuf_full = 1'b0; iobuf_empty = 1'b0; ipeng_busy = 1'b0;
    repeat (3) @(negedge iclk);
    check_all_zero("reset");
    ireset = 1'b0;
    @(negedge iclk);
    chk("clear_after_reset", openg_clear, 1);
    armed = 1'b1;
    wait_ecyc(ecyc + 2);

    // Nominal block
    chk("clear_idle", openg_clear, 1);
    ibuf_full = 1'b1; iobuf_empty = 1'b1; c0 = ecyc;
    push_block(c0, 0, 99);
    wait_ecyc(c0 + 1);
    ibuf_full = 1'b0; iobuf_empty = 1'b0;
    wait_ecyc(c0 + 3);
    chk("clear_in_block", openg_clear, 0);
    wait_ecyc(c0 + 12);
    chk("clear_after_block", openg_clear, 1);
    wait_ecyc(c0 + 14);

    // Output stall for 20 cycles, then nominal block
    ibuf_full = 1'b1;
    wait_ecyc(ecyc + 20);
    iobuf_empty = 1'b1; c0 = ecyc;
    push_block(c0, 0, 99);
    wait_ecyc(c0 + 1);
    ibuf_full = 1'b0; iobuf_empty = 1'b0;
    wait_ecyc(c0 + 14);

    // Parity engine busy for 5 cycles after the data phase
    ibuf_full = 1'b1; iobuf_empty = 1'b1; c0 = ecyc;
    push_block(c0, 5, 99);
    wait_ecyc(c0 + 1);
    ibuf_full = 1'b0; iobuf_empty = 1'b0;
    wait_ecyc(c0 + 4);
    ipeng_busy = 1'b1;
    wait_ecyc(c0 + 10);
    ipeng_busy = 1'b0;
    wait_ecyc(c0 + 19);

    // Reset at cycle 3 of a block, then a clean block
    ibuf_full = 1'b1; iobuf_empty = 1'b1; c0 = ecyc;
    push_block(c0, 0, 3);
    wait_ecyc(c0 + 1);
    ibuf_full = 1'b0; iobuf_empty = 1'b0;
    wait_ecyc(c0 + 3);
    ireset = 1'b1;
    @(negedge iclk);
    check_all_zero("abort");
    sb.delete();
    ireset = 1'b0;
    wait_ecyc(ecyc + 12);
    ibuf_full = 1'b1; iobuf_empty = 1'b1; c0 = ecyc;
    push_block(c0, 0, 99);
    wait_ecyc(c0 + 1);
    ibuf_full = 1'b0; iobuf_empty = 1'b0;
    wait_ecyc(c0 + 14);

    // Clock enable toggled every cycle during a block
    gate = 1'b1;
    ibuf_full = 1'b1; iobuf_empty = 1'b1; c0 = ecyc;
    push_block(c0, 0, 99);
    wait_ecyc(c0 + 1);
    ibuf_full = 1'b0; iobuf_empty = 1'b0;
    wait_ecyc(c0 + 14);
    gate = 1'b0; iclkena = 1'b1;
    wait_ecyc(ecyc + 2);

    // Back-to-back blocks
    ibuf_full = 1'b1; iobuf_empty = 1'b1; c0 = ecyc;
    push_block(c0, 0, 99);
    push_block(c0 + 11, 0, 99);
    wait_ecyc(c0 + 12);
    ibuf_full = 1'b0; iobuf_empty = 1'b0;
    wait_ecyc(c0 + 26);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
